dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between two requesters.
  - Port 0 is the CPU memory stage (LW/SW traffic).
  - Port 1 is the DMA/debug loader.
- Issues at most one RAM command per cycle and returns read data one cycle after grant.
- Asserts a stall to the pipeline while the CPU is waiting.
- CPU has fixed priority, with two exceptions: starvation protection and bounded DMA bursts.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: CPU memory stage (port 0) vs DMA/debug loader (port 1).
// One RAM command per cycle; CPU-first with starvation relief and DMA bursts.
module dmem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_burst,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {
    CPU_PRI,
    DMA_BURST
  } state_t;

  localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);
  localparam logic [7:0] BMAX = 8'(BURST_MAX);

  state_t     state;
  state_t     state_nx;
  logic [7:0] burst_cnt;
  logic [7:0] burst_nx;
  logic [7:0] starve_cnt;
  logic [7:0] starve_nx;
  logic       rd_pend;
  logic       rd_owner;
  logic       dma_first;
  logic       burst_done;

  // DMA takes a contended cycle while bursting or once starved
  always_comb begin
    dma_first = (state == DMA_BURST) || (starve_cnt == SLIM);
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    if (!rst) begin
      if (cpu_req && dma_req) begin
        cpu_gnt = !dma_first;
        dma_gnt = dma_first;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  always_comb begin
    ram_en    = cpu_gnt | dma_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // burst_cnt counts DMA grants in the current burst, entry grant included
  always_comb begin
    state_nx   = state;
    burst_nx   = burst_cnt;
    burst_done = dma_gnt && ((burst_cnt + 8'd1) >= BMAX);
    unique case (state)
      CPU_PRI: begin
        if (dma_gnt && dma_burst && (BMAX > 8'd1)) begin
          state_nx = DMA_BURST;
          burst_nx = 8'd1;
        end
      end
      DMA_BURST: begin
        if (!dma_req || !dma_burst || burst_done) begin
          state_nx = CPU_PRI;
          burst_nx = 8'd0;
        end else if (dma_gnt) begin
          burst_nx = burst_cnt + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    starve_nx = starve_cnt;
    if (!dma_req || dma_gnt) begin
      starve_nx = 8'd0;
    end else if (starve_cnt < SLIM) begin
      starve_nx = starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CPU_PRI;
      burst_cnt  <= 8'd0;
      starve_cnt <= 8'd0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_nx;
      burst_cnt  <= burst_nx;
      starve_cnt <= starve_nx;
      rd_pend    <= (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
      if (cpu_gnt | dma_gnt) begin
        rd_owner <= dma_gnt;
      end
    end
  end

  assign cpu_rvalid = rd_pend & ~rd_owner;
  assign dma_rvalid = rd_pend & rd_owner;
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
  assign dma_rdata  = dma_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, grant/return reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int STARVE_LIMIT = 8;
  localparam int BURST_MAX = 4;

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req;
  logic          dma_we;
  logic          dma_burst;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int failures = 0;
  logic mem_clr;
  logic chk_en;

  dmem_arbiter #(
    .AW(AW), .DW(DW),
    .STARVE_LIMIT(STARVE_LIMIT),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_burst(dma_burst), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM seen by the arbiter
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model: m_left = burst grants still owed to DMA
  logic [DW-1:0] shadow [1024];
  int            m_starve;
  int            m_left;
  bit            m_pend;
  bit            m_owner;
  logic [DW-1:0] m_pdata;

  function automatic bit dma_first();
    return (m_left != 0) || (m_starve == STARVE_LIMIT);
  endfunction

  function automatic bit f_cg();
    if (rst) return 1'b0;
    return cpu_req && !(dma_req && dma_first());
  endfunction

  function automatic bit f_dg();
    if (rst) return 1'b0;
    return dma_req && (!cpu_req || dma_first());
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) shadow[i] <= '0;
      m_pend <= 1'b0;
      m_owner <= 1'b0;
      m_pdata <= '0;
      m_starve <= 0;
      m_left <= 0;
    end else begin
      if (f_cg() && cpu_we) shadow[cpu_addr] <= cpu_wdata;
      if (f_dg() && dma_we) shadow[dma_addr] <= dma_wdata;
      m_pend <= (f_cg() && !cpu_we) || (f_dg() && !dma_we);
      if (f_cg()) m_owner <= 1'b0;
      if (f_dg()) m_owner <= 1'b1;
      m_pdata <= f_dg() ? shadow[dma_addr] : shadow[cpu_addr];
      if (rst || !dma_req || f_dg()) m_starve <= 0;
      else if (m_starve < STARVE_LIMIT) m_starve <= m_starve + 1;
      if (rst) m_left <= 0;
      else if (m_left == 0) begin
        if (f_dg() && dma_burst) m_left <= BURST_MAX - 1;
      end else if (!dma_req || !dma_burst) m_left <= 0;
      else if (f_dg()) m_left <= m_left - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit ecg;
      bit edg;
      logic ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ecg = f_cg();
      edg = f_dg();
      ewe = ecg ? cpu_we : (edg ? dma_we : 1'b0);
      ea = ecg ? cpu_addr : (edg ? dma_addr : '0);
      ed = ecg ? cpu_wdata : (edg ? dma_wdata : '0);
      chk("m_gnt",
          32'({cpu_gnt, dma_gnt, cpu_stall, ram_en, ram_we}),
          32'({ecg, edg, cpu_req & ~ecg, ecg | edg, ewe}));
      chk("m_ram_addr", 32'(ram_addr), 32'(ea));
      chk("m_ram_wdata", ram_wdata, ed);
      chk("m_rvalid", 32'({cpu_rvalid, dma_rvalid}),
          32'({m_pend & ~m_owner, m_pend & m_owner}));
      chk("m_cpu_rdata", cpu_rdata,
          (m_pend && !m_owner) ? m_pdata : '0);
      chk("m_dma_rdata", dma_rdata,
          (m_pend && m_owner) ? m_pdata : '0);
    end
  end

  task automatic step(input bit cr, input bit cw,
                      input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input bit dr, input bit dw, input bit db,
                      input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_burst = db;
    dma_addr = da; dma_wdata = dd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  function automatic logic [AW-1:0] raddr();
    logic [AW-1:0] base;
    base = ($urandom_range(0, 1) != 0) ? 10'h3F0 : 10'h000;
    return base | 10'($urandom_range(0, 15));
  endfunction

  initial begin
    int first;
    logic [13:0] pat;
    bit lcg;
    bit ldg;
    rst = 1'b1; mem_clr = 1'b1; chk_en = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_burst = 0;
    dma_addr = '0; dma_wdata = '0;
    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
    chk("rst_rdata", cpu_rdata | dma_rdata, 32'd0);

    // CPU alone: store then load
    step(1, 1, 10'h005, 32'hDEADBEEF, 0, 0, 0, '0, '0);
    chk("sw_gnt", 32'({cpu_gnt, cpu_stall}), 32'b10);
    step(1, 0, 10'h005, '0, 0, 0, 0, '0, '0);
    chk("lw_gnt", 32'({cpu_gnt, cpu_stall}), 32'b10);
    idle();
    chk("lw_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'b10);
    chk("lw_rdata", cpu_rdata, 32'hDEADBEEF);

    // Contention without burst: DMA gets the 9th cycle
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 10'(i), '0, 1, 0, 0, 10'h020, '0);
      if (dma_gnt && first == 0) first = i;
    end
    chk("starve_first_dma", 32'(first), 32'd9);
    chk("starve_after_gnt", 32'({cpu_gnt, dut.starve_cnt}), 32'h100);
    idle();

    // Burst: 4 DMA, 8 CPU, then starved DMA re-enters burst
    pat = '0;
    for (int i = 0; i < 14; i++) begin
      step(i > 0, 0, 10'(10'h040 + i), '0, 1, 0, 1, 10'h080, '0);
      pat[i] = dma_gnt;
    end
    chk("burst_pattern", 32'(pat), 32'h300F);
    idle();
    idle();

    // Interleaved reads by alternating ports
    step(0, 0, '0, '0, 1, 1, 0, 10'h3FF, 32'h12345678);
    step(1, 1, 10'h000, 32'h0000CAFE, 0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 0, 0, 10'h3FF, '0);
    chk("il_dma_gnt", 32'(dma_gnt), 32'd1);
    step(1, 0, 10'h000, '0, 0, 0, 0, '0, '0);
    chk("il_dma_rv", 32'({cpu_rvalid, dma_rvalid}), 32'b01);
    chk("il_dma_rd", dma_rdata, 32'h12345678);
    chk("il_cpu_rd0", cpu_rdata, 32'd0);
    idle();
    chk("il_cpu_rv", 32'({cpu_rvalid, dma_rvalid}), 32'b10);
    chk("il_cpu_rd", cpu_rdata, 32'h0000CAFE);
    chk("il_dma_rd0", dma_rdata, 32'd0);

    // Reset while a burst is open and a CPU load is presented
    step(0, 0, '0, '0, 1, 0, 1, 10'h3FF, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    @(negedge clk);
    chk("rst_gnt", 32'({cpu_gnt, dma_gnt, ram_en, ram_we}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_drop_rv", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
    chk("rst_cpu_wins", 32'({cpu_gnt, dma_gnt}), 32'b10);
    chk("rst_counters", 32'({dut.starve_cnt, dut.burst_cnt}), 32'd0);
    idle();
    idle();

    // Burst abort after two grants
    step(0, 0, '0, '0, 1, 0, 1, 10'h010, '0);
    step(1, 0, 10'h011, '0, 1, 0, 1, 10'h010, '0);
    chk("abort_2nd_dma", 32'(dma_gnt), 32'd1);
    step(1, 0, 10'h011, '0, 0, 0, 0, '0, '0);
    step(1, 0, 10'h012, '0, 1, 0, 0, 10'h010, '0);
    chk("abort_cpu_wins", 32'({cpu_gnt, dma_gnt}), 32'b10);
    chk("abort_burst_cnt", 32'(dut.burst_cnt), 32'd0);
    idle();

    // Random traffic; fields held until granted, occasional drop/reset
    lcg = 0;
    ldg = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      if (!cpu_req || lcg || $urandom_range(0, 15) == 0) begin
        cpu_req = ($urandom_range(0, 2) != 0);
        cpu_we = ($urandom_range(0, 1) != 0);
        cpu_addr = raddr();
        cpu_wdata = $urandom;
      end
      if (!dma_req || ldg || $urandom_range(0, 15) == 0) begin
        dma_req = ($urandom_range(0, 2) != 0);
        dma_we = ($urandom_range(0, 1) != 0);
        dma_addr = raddr();
        dma_wdata = $urandom;
      end
      dma_burst = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      lcg = cpu_gnt;
      ldg = dma_gnt;
    end

    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
